// File: rtl/div_unit_if.sv
// Pipeline-side signal bundle for the E-stage divider: operands and control in,
// {HI,LO} result, ready and stall request out.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               signed_div;
    logic               annul;
    logic               stall_ext;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_div;

    modport master (
        output opdata1, opdata2, start, signed_div, annul, stall_ext,
        input  result, ready, stall_div
    );

    modport slave (
        input  opdata1, opdata2, start, signed_div, annul, stall_ext,
        output result, ready, stall_div
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} after WIDTH iterations and stalls the pipeline meanwhile.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DIV_ZERO, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Magnitudes wrap for the most negative value, which is still correct read as unsigned.
    always_comb begin
        dividend_mag = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        divisor_mag  = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
        shifted      = {1'b0, partial} << 1;
        diff         = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
        step         = diff[WIDTH] ? shifted[2*WIDTH-1:0]
                                   : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        quo_fixed    = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem_fixed    = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            partial  <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (bus.annul) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.opdata2 == '0) begin
                            state <= DIV_ZERO;
                        end else begin
                            state   <= BUSY;
                            partial <= {{WIDTH{1'b0}}, dividend_mag};
                            divisor <= divisor_mag;
                            neg_q   <= bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                            neg_r   <= bus.signed_div && bus.opdata1[WIDTH-1];
                            counter <= '0;
                        end
                    end
                end
                DIV_ZERO: begin
                    state    <= DONE;
                    result_q <= '0;
                    ready_q  <= 1'b1;
                end
                // The last iteration's step feeds the sign fix directly on the DONE entry edge.
                BUSY: begin
                    partial <= step;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_ITER) begin
                        state    <= DONE;
                        result_q <= {rem_fixed, quo_fixed};
                        ready_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.stall_ext) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.ready     = ready_q;
    assign bus.stall_div = ((state == IDLE) && bus.start && !bus.annul)
                         || (state == BUSY) || (state == DIV_ZERO);
endmodule
